// File: rtl/xadc_pkg.sv
// Shared definitions for the XADC DRP sequencer.
//   - DRP status addresses of the two auxiliary channels that are sampled
//   - sample / counter widths
//   - sequencer FSM state encoding and channel tag encoding
package xadc_pkg;

  localparam int unsigned SAMPLE_W = 12;
  localparam int unsigned COUNT_W  = 11;

  localparam logic [6:0] ADDR_SWITCH_DEF = 7'h10;  // VAUX0, switch signal
  localparam logic [6:0] ADDR_FEED_DEF   = 7'h11;  // VAUX1, feed signal

  typedef enum logic [2:0] {
    StIdle,
    StWaitEoc,
    StIssue,
    StWaitRdy,
    StEmit,
    StDone
  } state_e;

  typedef enum logic {
    ChanSwitch = 1'b0,
    ChanFeed   = 1'b1
  } chan_e;

endpackage

// File: rtl/drp_timeout_timer.sv
// DRP read watchdog.
//   clk    : clock
//   clr    : asynchronous active-high reset
//   load   : restart the count (asserted in the cycle the DRP enable is issued)
//   en     : count while waiting for drdy
//   expire : one-cycle pulse; TIMEOUT_CYCLES cycles have elapsed since load
//            once the current clock edge is taken
module drp_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic clr,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q;

  // The load cycle (den) is the first elapsed cycle, so the count starts at 1.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CntW'(1);
    end else if (en && (cnt_q != LastCnt)) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign expire = en && (cnt_q == LastCnt);

endmodule

// File: rtl/xadc_drp_sequencer.sv
// Sequences DRP status reads from the XADC wrapper in continuous-sequence mode.
// Each end-of-conversion on the switch or feed channel triggers one DRP read;
// the 12 MSBs are emitted with a channel tag and counted per channel until both
// channels hold MAX_SAMPLES, at which point the block is flagged complete.
//   clk, clr                 : clock, asynchronous active-high reset
//   start                    : begin a block (ignored while busy)
//   eoc_in, channel_in       : XADC end-of-conversion and channel number
//   drp_*                    : DRP read port towards the XADC
//   busy                     : block in progress
//   sample_valid/chan/data   : emitted sample
//   count_switch, count_feed : per-channel sample counts in this block
//   block_done               : both counts reached MAX_SAMPLES
//   overrun_err, timeout_err : sticky error flags, cleared by start
module xadc_drp_sequencer
  import xadc_pkg::*;
#(
  parameter int unsigned MAX_SAMPLES    = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [6:0]  ADDR_SWITCH    = ADDR_SWITCH_DEF,
  parameter logic [6:0]  ADDR_FEED      = ADDR_FEED_DEF
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic                eoc_in,
  input  logic [4:0]          channel_in,
  output logic [6:0]          drp_daddr,
  output logic                drp_den,
  output logic                drp_dwe,
  output logic [15:0]         drp_di,
  input  logic [15:0]         drp_do,
  input  logic                drp_drdy,
  output logic                busy,
  output logic                sample_valid,
  output logic                sample_chan,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic [COUNT_W-1:0]  count_switch,
  output logic [COUNT_W-1:0]  count_feed,
  output logic                block_done,
  output logic                overrun_err,
  output logic                timeout_err
);

  localparam logic [COUNT_W-1:0] MaxCnt = COUNT_W'(MAX_SAMPLES);

  state_e              state_q, state_d;
  logic [COUNT_W-1:0]  cnt_sw_q, cnt_sw_d, cnt_fd_q, cnt_fd_d;
  logic [6:0]          daddr_q, daddr_d;
  chan_e               chan_q, chan_d;
  logic [SAMPLE_W-1:0] data_q, data_d;
  logic                ovr_q, ovr_d, tmo_q, tmo_d;
  logic                tmr_load, tmr_en, tmr_expire;
  logic                sw_hit, fd_hit;

  // A conversion is only of interest while its channel still needs samples.
  assign sw_hit = eoc_in && (channel_in == ADDR_SWITCH[4:0]) && (cnt_sw_q < MaxCnt);
  assign fd_hit = eoc_in && (channel_in == ADDR_FEED[4:0]) && (cnt_fd_q < MaxCnt);

  drp_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .clr   (clr),
    .load  (tmr_load),
    .en    (tmr_en),
    .expire(tmr_expire)
  );

  always_comb begin
    state_d  = state_q;
    cnt_sw_d = cnt_sw_q;
    cnt_fd_d = cnt_fd_q;
    daddr_d  = daddr_q;
    chan_d   = chan_q;
    data_d   = data_q;
    ovr_d    = ovr_q;
    tmo_d    = tmo_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          cnt_sw_d = '0;
          cnt_fd_d = '0;
          ovr_d    = 1'b0;
          tmo_d    = 1'b0;
          state_d  = StWaitEoc;
        end
      end
      StWaitEoc: begin
        if (sw_hit) begin
          daddr_d = ADDR_SWITCH;
          chan_d  = ChanSwitch;
          state_d = StIssue;
        end else if (fd_hit) begin
          daddr_d = ADDR_FEED;
          chan_d  = ChanFeed;
          state_d = StIssue;
        end
      end
      StIssue: begin
        tmr_load = 1'b1;
        if (sw_hit || fd_hit) ovr_d = 1'b1;
        state_d = StWaitRdy;
      end
      StWaitRdy: begin
        tmr_en = 1'b1;
        if (sw_hit || fd_hit) ovr_d = 1'b1;
        // drdy wins over an expiry landing in the same cycle
        if (drp_drdy) begin
          data_d  = drp_do[15:4];
          state_d = StEmit;
        end else if (tmr_expire) begin
          tmo_d   = 1'b1;
          state_d = StWaitEoc;
        end
      end
      StEmit: begin
        if (sw_hit || fd_hit) ovr_d = 1'b1;
        if (chan_q == ChanSwitch) begin
          if (cnt_sw_q < MaxCnt) cnt_sw_d = cnt_sw_q + 11'd1;
        end else begin
          if (cnt_fd_q < MaxCnt) cnt_fd_d = cnt_fd_q + 11'd1;
        end
        if ((cnt_sw_d == MaxCnt) && (cnt_fd_d == MaxCnt)) begin
          state_d = StDone;
        end else begin
          state_d = StWaitEoc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= StIdle;
      cnt_sw_q <= '0;
      cnt_fd_q <= '0;
      daddr_q  <= '0;
      chan_q   <= ChanSwitch;
      data_q   <= '0;
      ovr_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_sw_q <= cnt_sw_d;
      cnt_fd_q <= cnt_fd_d;
      daddr_q  <= daddr_d;
      chan_q   <= chan_d;
      data_q   <= data_d;
      ovr_q    <= ovr_d;
      tmo_q    <= tmo_d;
    end
  end

  assign drp_daddr    = daddr_q;
  assign drp_den      = (state_q == StIssue);
  assign drp_dwe      = 1'b0;
  assign drp_di       = '0;
  assign busy         = (state_q == StWaitEoc) || (state_q == StIssue) ||
                        (state_q == StWaitRdy) || (state_q == StEmit);
  assign sample_valid = (state_q == StEmit);
  assign sample_chan  = chan_q;
  assign sample_data  = data_q;
  assign count_switch = cnt_sw_q;
  assign count_feed   = cnt_fd_q;
  assign block_done   = (state_q == StDone);
  assign overrun_err  = ovr_q;
  assign timeout_err  = tmo_q;

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// Bench for xadc_drp_sequencer with a 4-sample block and a behavioural DRP
// responder. Inputs are driven and outputs sampled on the falling clock edge.
module tb_xadc_drp_sequencer;

  logic        clk = 1'b0;
  logic        clr, start, eoc_in;
  logic [4:0]  channel_in;
  logic [6:0]  drp_daddr;
  logic        drp_den, drp_dwe;
  logic [15:0] drp_di, drp_do;
  logic        drp_drdy;
  logic        busy, sample_valid, sample_chan;
  logic [11:0] sample_data;
  logic [10:0] count_switch, count_feed;
  logic        block_done, overrun_err, timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  // DRP responder settings: data returned and drdy delay after den (0 = never)
  logic [15:0] drp_data;
  int          drp_lat;
  int          drp_cd = 0;

  always #5 clk = ~clk;

  xadc_drp_sequencer #(
    .MAX_SAMPLES   (4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .eoc_in      (eoc_in),
    .channel_in  (channel_in),
    .drp_daddr   (drp_daddr),
    .drp_den     (drp_den),
    .drp_dwe     (drp_dwe),
    .drp_di      (drp_di),
    .drp_do      (drp_do),
    .drp_drdy    (drp_drdy),
    .busy        (busy),
    .sample_valid(sample_valid),
    .sample_chan (sample_chan),
    .sample_data (sample_data),
    .count_switch(count_switch),
    .count_feed  (count_feed),
    .block_done  (block_done),
    .overrun_err (overrun_err),
    .timeout_err (timeout_err)
  );

  // drdy is raised drp_lat cycles after the den cycle, independent of clr.
  always @(negedge clk) begin
    drp_drdy = 1'b0;
    if (drp_cd > 0) begin
      drp_cd = drp_cd - 1;
      if (drp_cd == 0) begin
        drp_drdy = 1'b1;
        drp_do   = drp_data;
      end
    end
    if (drp_den && drp_lat != 0) drp_cd = drp_lat;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  ch;
    logic [15:0] dout;
    int          lat;
    logic        exp_den;
    logic        exp_chan;
    logic [11:0] exp_data;
    logic [10:0] exp_cs;
    logic [10:0] exp_cf;
  } vec_t;

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One eoc; checks den timing, sample timing/content and resulting counts.
  task automatic run_txn(input vec_t v, input string tag);
    logic early;
    early      = 1'b0;
    drp_data   = v.dout;
    drp_lat    = v.lat;
    channel_in = v.ch;
    eoc_in     = 1'b1;
    @(negedge clk);
    eoc_in = 1'b0;
    check({tag, " den"}, 32'(drp_den), 32'(v.exp_den));
    if (v.exp_den) begin
      check({tag, " daddr"}, 32'(drp_daddr), 32'({2'b00, v.ch}));
      for (int i = 0; i <= v.lat; i++) begin
        if (i < v.lat) early = early | sample_valid;
        @(negedge clk);
      end
      check({tag, " early valid"}, 32'(early), 32'(0));
      check({tag, " valid"}, 32'(sample_valid), 32'(1));
      check({tag, " chan"}, 32'(sample_chan), 32'(v.exp_chan));
      check({tag, " data"}, 32'(sample_data), 32'(v.exp_data));
      @(negedge clk);
    end else begin
      for (int i = 0; i < 3; i++) begin
        early = early | sample_valid | drp_den;
        @(negedge clk);
      end
      check({tag, " no activity"}, 32'(early), 32'(0));
    end
    check({tag, " count_switch"}, 32'(count_switch), 32'(v.exp_cs));
    check({tag, " count_feed"}, 32'(count_feed), 32'(v.exp_cf));
  endtask

  vec_t vecs[12];

  initial begin
    int   pulses, dens;
    vec_t v;

    vecs[0]  = '{5'h10, 16'hABC0, 3, 1'b1, 1'b0, 12'hABC, 11'd1, 11'd0};
    vecs[1]  = '{5'h11, 16'hABC0, 3, 1'b1, 1'b1, 12'hABC, 11'd1, 11'd1};
    vecs[2]  = '{5'h05, 16'h0000, 3, 1'b0, 1'b0, 12'h000, 11'd1, 11'd1};
    vecs[3]  = '{5'h10, 16'h1234, 1, 1'b1, 1'b0, 12'h123, 11'd2, 11'd1};
    vecs[4]  = '{5'h11, 16'hFFFF, 2, 1'b1, 1'b1, 12'hFFF, 11'd2, 11'd2};
    vecs[5]  = '{5'h10, 16'h0000, 3, 1'b1, 1'b0, 12'h000, 11'd3, 11'd2};
    vecs[6]  = '{5'h11, 16'h800F, 1, 1'b1, 1'b1, 12'h800, 11'd3, 11'd3};
    vecs[7]  = '{5'h10, 16'h5A5A, 4, 1'b1, 1'b0, 12'h5A5, 11'd4, 11'd3};
    vecs[8]  = '{5'h10, 16'h1110, 3, 1'b0, 1'b0, 12'h000, 11'd4, 11'd3};
    vecs[9]  = '{5'h11, 16'h7770, 3, 1'b1, 1'b1, 12'h777, 11'd4, 11'd4};
    vecs[10] = '{5'h10, 16'h2220, 3, 1'b0, 1'b0, 12'h000, 11'd4, 11'd4};
    vecs[11] = '{5'h11, 16'h3330, 3, 1'b0, 1'b0, 12'h000, 11'd4, 11'd4};

    clr = 1'b1; start = 1'b0; eoc_in = 1'b0; channel_in = '0;
    drp_data = '0; drp_lat = 0; drp_do = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'(0));
    check("reset daddr", 32'(drp_daddr), 32'(0));
    check("reset outputs", 32'({drp_den, sample_valid, sample_chan, block_done,
                                overrun_err, timeout_err}), 32'(0));
    check("reset counts", 32'({count_switch, count_feed}), 32'(0));
    clr = 1'b0;
    @(negedge clk);
    pulse_start();
    check("start busy", 32'(busy), 32'(1));

    // Block of 4+4 samples, with ineligible and over-quota conversions mixed in
    for (int i = 0; i < 12; i++) begin
      if (i == 2) begin
        pulse_start();  // ignored while busy
        check("start while busy counts", 32'({count_switch, count_feed}),
              32'({11'd1, 11'd1}));
      end
      run_txn(vecs[i], $sformatf("vec%0d", i));
      if (i == 9) begin
        check("block_done after 8th", 32'(block_done), 32'(1));
        check("busy after 8th", 32'(busy), 32'(0));
      end
    end
    check("dwe/di tied", 32'({drp_dwe, drp_di}), 32'(0));
    check("no errors block1", 32'({overrun_err, timeout_err}), 32'(0));
    check("done hold", 32'(block_done), 32'(1));

    // Restart from DONE
    pulse_start();
    check("restart block_done", 32'(block_done), 32'(0));
    check("restart busy", 32'(busy), 32'(1));
    check("restart counts", 32'({count_switch, count_feed}), 32'(0));

    // DRP read that never completes
    drp_lat = 0; channel_in = 5'h10; eoc_in = 1'b1;
    @(negedge clk);
    eoc_in = 1'b0;
    check("tmo den", 32'(drp_den), 32'(1));
    pulses = 0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      pulses += int'(sample_valid);
      if (i == 63) check("tmo not yet", 32'(timeout_err), 32'(0));
    end
    check("tmo set", 32'(timeout_err), 32'(1));
    check("tmo no sample", 32'(pulses), 32'(0));
    check("tmo counts", 32'({count_switch, count_feed}), 32'(0));
    v = '{5'h10, 16'h2460, 3, 1'b1, 1'b0, 12'h246, 11'd1, 11'd0};
    run_txn(v, "after tmo");
    check("tmo sticky", 32'(timeout_err), 32'(1));
    check("no overrun yet", 32'(overrun_err), 32'(0));

    // Second eligible eoc arriving during ISSUE
    drp_data = 16'h4560; drp_lat = 3; channel_in = 5'h11; eoc_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    eoc_in = 1'b0;
    check("overrun set", 32'(overrun_err), 32'(1));
    pulses = 0; dens = 0;
    for (int i = 0; i < 8; i++) begin
      pulses += int'(sample_valid);
      dens   += int'(drp_den);
      @(negedge clk);
    end
    check("overrun one sample", 32'(pulses), 32'(1));
    check("overrun no 2nd den", 32'(dens), 32'(0));
    check("overrun data", 32'(sample_data), 32'(12'h456));
    check("overrun count_feed", 32'(count_feed), 32'(1));

    // clr while waiting for drdy; the late drdy must be ignored
    drp_data = 16'hDEF0; drp_lat = 3; channel_in = 5'h10; eoc_in = 1'b1;
    @(negedge clk);
    eoc_in = 1'b0;
    check("clr den", 32'(drp_den), 32'(1));
    @(negedge clk);
    clr = 1'b1;
    #1;
    check("clr busy", 32'(busy), 32'(0));
    check("clr counts", 32'({count_switch, count_feed}), 32'(0));
    check("clr flags", 32'({drp_den, sample_valid, overrun_err, timeout_err,
                            block_done, sample_chan}), 32'(0));
    check("clr daddr/data", 32'({drp_daddr, sample_data}), 32'(0));
    @(negedge clk);
    clr = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pulses += int'(sample_valid);
    end
    check("clr no sample", 32'(pulses), 32'(0));
    check("clr idle busy", 32'(busy), 32'(0));
    pulse_start();
    check("fresh start busy", 32'(busy), 32'(1));
    v = '{5'h10, 16'h3210, 2, 1'b1, 1'b0, 12'h321, 11'd1, 11'd0};
    run_txn(v, "fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
